// File: rtl/overlay_text_sequencer_pkg.sv
// Shared definitions for the overlay blocks: sequencer state encoding, the
// overlay gold colour, and small arithmetic helpers.
package overlay_text_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REVEAL = 2'd1,
    ST_HOLD   = 2'd2,
    ST_BLINK  = 2'd3
  } ovl_state_e;

  localparam logic [5:0] GOLD_COLOUR = 6'b110110;

  // Message index advance with wrap at the last selectable message.
  function automatic logic [1:0] wrap_inc_sel(input logic [1:0] sel,
                                              input logic [1:0] last);
    return (sel == last) ? 2'd0 : (sel + 2'd1);
  endfunction

  // True when the post-increment blink tick count closes a half-period.
  function automatic logic on_half_boundary(input logic [7:0] cnt_next,
                                            input logic [7:0] half);
    return ((cnt_next % half) == 8'd0);
  endfunction

endpackage

// File: rtl/overlay_text_sequencer_if.sv
// Control and status bundle between a video controller and the overlay text
// sequencer.
interface overlay_text_sequencer_if;
  logic       vsync;
  logic       start;
  logic       loop_en;
  logic       abort;
  logic [1:0] msg_sel;
  logic [3:0] chars_visible;
  logic       text_on;
  logic       busy;

  modport master (
    output vsync, start, loop_en, abort,
    input  msg_sel, chars_visible, text_on, busy
  );

  modport slave (
    input  vsync, start, loop_en, abort,
    output msg_sel, chars_visible, text_on, busy
  );
endinterface

// File: rtl/overlay_text_sequencer_frame_tick_gen.sv
// Turns a clk-synchronous vsync level into a one-cycle frame pulse, issued the
// cycle after a rising edge is seen. Reusable by any frame-paced overlay.
module frame_tick_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic frame_tick
);

  logic vsync_r;
  logic tick_r;

  // History resets high so a vsync held high across reset yields no pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_r <= 1'b1;
      tick_r  <= 1'b0;
    end else begin
      vsync_r <= vsync;
      tick_r  <= vsync & ~vsync_r;
    end
  end

  assign frame_tick = tick_r;

endmodule

// File: rtl/overlay_text_sequencer.sv
// Frame-paced overlay text animation: reveal characters one by one, hold the
// full message, blink, then advance to the next message or stop.
module overlay_text_sequencer
  import overlay_text_sequencer_pkg::*;
#(
  parameter int unsigned NUM_MSGS     = 4,
  parameter int unsigned MSG_LEN      = 12,
  parameter int unsigned CHAR_FRAMES  = 6,
  parameter int unsigned HOLD_FRAMES  = 120,
  parameter int unsigned BLINK_FRAMES = 48,
  parameter int unsigned BLINK_HALF   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  overlay_text_sequencer_if.slave  bus
);

  localparam logic [7:0] CHAR_LAST  = 8'(CHAR_FRAMES - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] HALF_LEN   = 8'(BLINK_HALF);
  localparam logic [3:0] MSG_LAST   = 4'(MSG_LEN - 1);
  localparam logic [1:0] SEL_LAST   = 2'(NUM_MSGS - 1);

  ovl_state_e state_r;
  logic [7:0] frame_cnt_r;
  logic [1:0] msg_sel_r;
  logic [3:0] chars_visible_r;
  logic       text_on_r;
  logic       busy_r;
  logic       frame_tick_s;
  logic [7:0] cnt_inc_s;

  frame_tick_gen u_frame_tick_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (bus.vsync),
    .frame_tick (frame_tick_s)
  );

  assign cnt_inc_s = frame_cnt_r + 8'd1;

  // Sequencer FSM; the frame counter is cleared on every state change and
  // only advances on frame ticks, so outputs never move mid-frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      frame_cnt_r     <= 8'd0;
      msg_sel_r       <= 2'd0;
      chars_visible_r <= 4'd0;
      text_on_r       <= 1'b0;
      busy_r          <= 1'b0;
    end else if (bus.abort) begin
      // Abort beats start and discards any tick arriving in the same cycle.
      state_r         <= ST_IDLE;
      frame_cnt_r     <= 8'd0;
      chars_visible_r <= 4'd0;
      text_on_r       <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_r         <= ST_REVEAL;
            frame_cnt_r     <= 8'd0;
            chars_visible_r <= 4'd0;
            text_on_r       <= 1'b1;
            busy_r          <= 1'b1;
          end
        end

        ST_REVEAL: begin
          if (frame_tick_s) begin
            if (frame_cnt_r == CHAR_LAST) begin
              frame_cnt_r     <= 8'd0;
              chars_visible_r <= chars_visible_r + 4'd1;
              if (chars_visible_r == MSG_LAST) begin
                state_r <= ST_HOLD;
              end
            end else begin
              frame_cnt_r <= cnt_inc_s;
            end
          end
        end

        ST_HOLD: begin
          if (frame_tick_s) begin
            if (frame_cnt_r == HOLD_LAST) begin
              state_r     <= ST_BLINK;
              frame_cnt_r <= 8'd0;
              text_on_r   <= 1'b0;
            end else begin
              frame_cnt_r <= cnt_inc_s;
            end
          end
        end

        ST_BLINK: begin
          if (frame_tick_s) begin
            if (frame_cnt_r == BLINK_LAST) begin
              // loop_en matters only on this exit tick.
              frame_cnt_r     <= 8'd0;
              chars_visible_r <= 4'd0;
              msg_sel_r       <= wrap_inc_sel(msg_sel_r, SEL_LAST);
              text_on_r       <= bus.loop_en;
              busy_r          <= bus.loop_en;
              state_r         <= bus.loop_en ? ST_REVEAL : ST_IDLE;
            end else begin
              frame_cnt_r <= cnt_inc_s;
              if (on_half_boundary(cnt_inc_s, HALF_LEN)) begin
                text_on_r <= ~text_on_r;
              end
            end
          end
        end

        default: begin
          state_r         <= ST_IDLE;
          frame_cnt_r     <= 8'd0;
          chars_visible_r <= 4'd0;
          text_on_r       <= 1'b0;
          busy_r          <= 1'b0;
        end
      endcase
    end
  end

  assign bus.msg_sel       = msg_sel_r;
  assign bus.chars_visible = chars_visible_r;
  assign bus.text_on       = text_on_r;
  assign bus.busy          = busy_r;

endmodule

// File: doc/overlay_text_sequencer.md
OVERLAY_TEXT_SEQUENCER -- requirements
Module: overlay_text_sequencer

Interface
REQ-001 SHALL have parameter NUM_MSGS, default 4, meaning number of selectable overlay messages (2..4).
REQ-002 SHALL have parameter MSG_LEN, default 12, meaning characters per message (1..15).
REQ-003 SHALL have parameter CHAR_FRAMES, default 6, meaning frames between successive character reveals (1..255).
REQ-004 SHALL have parameter HOLD_FRAMES, default 120, meaning frames the full message stays steady (1..255).
REQ-005 SHALL have parameter BLINK_FRAMES, default 48, meaning total blink-phase length in frames (1..255).
REQ-006 SHALL have parameter BLINK_HALF, default 8, meaning frames per blink on/off half-period (1..255).
REQ-007 SHALL have port clk  input  1  pixel clock; the only clock.
REQ-008 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-009 SHALL have port vsync  input  1  VGA vertical sync level, active-high, synchronous to clk.
REQ-010 SHALL have port start  input  1  single-cycle request to begin a sequence.
REQ-011 SHALL have port loop_en  input  1  continue with the next message after BLINK instead of returning to IDLE.
REQ-012 SHALL have port abort  input  1  single-cycle request to stop and blank.
REQ-013 SHALL have port msg_sel  output  2  message index for the text generator.
REQ-014 SHALL have port chars_visible  output  4  count of leading characters to draw (0..MSG_LEN).
REQ-015 SHALL have port text_on  output  1  overlay draw enable.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL register vsync and produce frame_tick as a one-cycle pulse on the cycle after a 0->1 edge is seen.
REQ-018 SHALL keep one 8-bit frame counter; it counts frame_ticks only, clears on every state change, and changes no other state between ticks.
REQ-019 SHALL update all outputs only on frame_tick cycles or in response to start, abort, or reset, so no output changes mid-frame except on those events.
REQ-020 SHALL implement FSM states IDLE, REVEAL, HOLD, BLINK.
REQ-021 IDLE: start -> REVEAL on the next cycle, with chars_visible=0, text_on=1, and msg_sel unchanged.
REQ-022 REVEAL: when frame count reaches CHAR_FRAMES-1 on a tick, increment chars_visible and clear the counter; the tick that makes chars_visible reach MSG_LEN moves to HOLD.
REQ-023 HOLD: after HOLD_FRAMES ticks -> BLINK with text_on=0.
REQ-024 BLINK: toggle text_on after every BLINK_HALF ticks; after BLINK_FRAMES ticks total, set text_on=0, chars_visible=0, and msg_sel=(msg_sel+1) mod NUM_MSGS; then go to REVEAL with text_on=1 if loop_en=1, otherwise go to IDLE.
REQ-025 SHALL sample loop_en on the BLINK exit tick only.
REQ-026 SHALL ignore start while busy=1.
REQ-027 abort in any state -> IDLE on the next cycle with text_on=0 and chars_visible=0; msg_sel is held.
REQ-028 abort and start in the same cycle: abort wins.
REQ-029 abort in the same cycle as frame_tick: abort wins and the tick is discarded.
REQ-030 msg_sel SHALL wrap from NUM_MSGS-1 to 0.
REQ-031 SHALL allow no combinational path from any input to any output.

Reset
REQ-032 rst_n=0 at a clk edge SHALL force IDLE, msg_sel=0, chars_visible=0, text_on=0, busy=0, frame counter=0, and the vsync history register=1 so that a vsync held high through reset does not produce a tick.
REQ-033 Reset asserted mid-sequence SHALL take priority over start, abort, and frame_tick.

Structure
REQ-034 The FSM state encoding and the gold colour constant 6'b110110 SHALL live in a shared overlay package used by the overlay blocks.
REQ-035 SHALL instantiate one sub-module, frame_tick_gen (vsync edge detector, REQ-017), which is reusable by other animated overlays.
REQ-036 The text generator SHALL gate drawing with text_on and (char_pos < chars_visible); this block does not drive pixel data.

Verification (CHAR_FRAMES=2, HOLD_FRAMES=4, BLINK_FRAMES=4, BLINK_HALF=2, MSG_LEN=12, NUM_MSGS=4)
REQ-037 start, then 24 vsync pulses -> chars_visible steps 0,1,..,12, one step every 2 ticks; on tick 24 state=HOLD with text_on=1.
REQ-038 4 more ticks -> BLINK; text_on=0 for 2 ticks, 1 for 2 ticks; with loop_en=0 -> IDLE, msg_sel=1, busy=0.
REQ-039 loop_en=1 with msg_sel=3 at BLINK exit -> msg_sel=0 and REVEAL restarts with chars_visible=0.
REQ-040 abort pulsed in the same cycle as frame_tick during REVEAL at chars_visible=5 -> next cycle IDLE, chars_visible=0, text_on=0, msg_sel unchanged.
REQ-041 start pulsed during HOLD -> no change to state or counters; vsync held high through reset release -> no tick until the next 0->1 edge.
REQ-042 rst_n=0 for one cycle during BLINK -> all outputs at the REQ-032 values on the following cycle.
